udma_l2_mem_responder: RTL

- Synthesizable L2 memory responder that answers the uDMA subsystem's two L2 initiator ports: ro (TX-channel reads) and wo (RX-channel writes).
- Implements the PULP TCDM slave side of the protocol:
  - req/gnt address phase;
  - rvalid/rdata response phase exactly one cycle after grant.
- Can inject bounded pseudo-random grant stalls to stress uDMA back-pressure.
- Used as the L2 model in uDMA subsystem benches and in FPGA bring-up in place of the real L2 interconnect.

---
 rtl/udma_l2_mem_responder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/udma_l2_mem_responder.sv
// L2 memory model answering the uDMA ro/wo TCDM initiator ports.
// Single-cycle response latency, optional LFSR-driven grant stalls.
module udma_l2_mem_responder #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           MEM_WORDS  = 8192,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1C00_0000,
   parameter int unsigned           MAX_STALL  = 3,
   parameter logic [15:0]           LFSR_SEED  = 16'hACE1
) (
   input  logic                      sys_clk_i,
   input  logic                      sys_resetn_i,
   input  logic                      stall_en_i,
   input  logic                      L2_ro_req_i,
   output logic                      L2_ro_gnt_o,
   input  logic                      L2_ro_wen_i,
   input  logic [ADDR_WIDTH-1:0]     L2_ro_addr_i,
   input  logic [DATA_WIDTH/8-1:0]   L2_ro_be_i,
   input  logic [DATA_WIDTH-1:0]     L2_ro_wdata_i,
   output logic                      L2_ro_rvalid_o,
   output logic [DATA_WIDTH-1:0]     L2_ro_rdata_o,
   input  logic                      L2_wo_req_i,
   output logic                      L2_wo_gnt_o,
   input  logic                      L2_wo_wen_i,
   input  logic [ADDR_WIDTH-1:0]     L2_wo_addr_i,
   input  logic [DATA_WIDTH/8-1:0]   L2_wo_be_i,
   input  logic [DATA_WIDTH-1:0]     L2_wo_wdata_i,
   output logic                      L2_wo_rvalid_o,
   output logic [DATA_WIDTH-1:0]     L2_wo_rdata_o,
   output logic [15:0]               ro_cnt_o,
   output logic [15:0]               wo_cnt_o,
   output logic                      addr_err_o
);

   localparam int unsigned           BE_W      = DATA_WIDTH / 8;
   localparam int unsigned           IDX_W     = $clog2(MEM_WORDS);
   localparam int unsigned           SC_W      = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
   localparam logic [SC_W-1:0]       STALL_MAX = SC_W'(MAX_STALL);
   localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * 4);
   localparam logic [DATA_WIDTH-1:0] ERR_DATA  = DATA_WIDTH'(32'hDEAD_BEEF);

   function automatic logic [ADDR_WIDTH-1:0] offset_of(input logic [ADDR_WIDTH-1:0] addr);
      return addr - BASE_ADDR;
   endfunction

   logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

   logic [15:0]           lfsr_q, lfsr_d;
   logic [SC_W-1:0]       ro_stall_cnt_q, ro_stall_cnt_d, wo_stall_cnt_q, wo_stall_cnt_d;
   logic                  ro_rvalid_q, ro_rvalid_d, wo_rvalid_q, wo_rvalid_d;
   logic [DATA_WIDTH-1:0] ro_rdata_q, ro_rdata_d, wo_rdata_q, wo_rdata_d;
   logic [15:0]           ro_cnt_q, ro_cnt_d, wo_cnt_q, wo_cnt_d;
   logic                  addr_err_q, addr_err_d;

   logic                  ro_stall, ro_gnt, ro_acc, ro_in_range, ro_we;
   logic                  wo_stall, wo_gnt, wo_acc, wo_in_range, wo_we;
   logic [ADDR_WIDTH-1:0] ro_offset, wo_offset;
   logic [IDX_W-1:0]      ro_idx, wo_idx;

   // Grant, decode and next-state logic for both ports and shared state
   always_comb begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

      ro_offset   = offset_of(L2_ro_addr_i);
      ro_idx      = ro_offset[IDX_W+1:2];
      ro_in_range = (ro_offset < MEM_BYTES);
      ro_stall    = stall_en_i & lfsr_q[0] & (ro_stall_cnt_q != STALL_MAX);
      ro_gnt      = L2_ro_req_i & ~ro_stall;
      ro_acc      = L2_ro_req_i & ro_gnt;
      ro_we       = ro_acc & ~L2_ro_wen_i & ro_in_range;

      wo_offset   = offset_of(L2_wo_addr_i);
      wo_idx      = wo_offset[IDX_W+1:2];
      wo_in_range = (wo_offset < MEM_BYTES);
      wo_stall    = stall_en_i & lfsr_q[8] & (wo_stall_cnt_q != STALL_MAX);
      wo_gnt      = L2_wo_req_i & ~wo_stall;
      wo_acc      = L2_wo_req_i & wo_gnt;
      wo_we       = wo_acc & ~L2_wo_wen_i & wo_in_range;

      // A stall run only counts while the request is held
      if (L2_ro_req_i && ro_stall) begin
         ro_stall_cnt_d = ro_stall_cnt_q + SC_W'(1);
      end else begin
         ro_stall_cnt_d = '0;
      end
      if (L2_wo_req_i && wo_stall) begin
         wo_stall_cnt_d = wo_stall_cnt_q + SC_W'(1);
      end else begin
         wo_stall_cnt_d = '0;
      end

      ro_rvalid_d = ro_acc;
      ro_rdata_d  = ro_rdata_q;
      if (ro_acc) begin
         if (L2_ro_wen_i) begin
            ro_rdata_d = ro_in_range ? mem_q[ro_idx] : ERR_DATA;
         end else begin
            ro_rdata_d = '0;
         end
      end else begin
         ro_rdata_d = ro_rdata_q;
      end

      wo_rvalid_d = wo_acc;
      wo_rdata_d  = wo_rdata_q;
      if (wo_acc) begin
         if (L2_wo_wen_i) begin
            wo_rdata_d = wo_in_range ? mem_q[wo_idx] : ERR_DATA;
         end else begin
            wo_rdata_d = '0;
         end
      end else begin
         wo_rdata_d = wo_rdata_q;
      end

      if (ro_acc) begin
         ro_cnt_d = ro_cnt_q + 16'd1;
      end else begin
         ro_cnt_d = ro_cnt_q;
      end
      if (wo_acc) begin
         wo_cnt_d = wo_cnt_q + 16'd1;
      end else begin
         wo_cnt_d = wo_cnt_q;
      end

      addr_err_d = addr_err_q | (ro_acc & ~ro_in_range) | (wo_acc & ~wo_in_range);
   end

   // Control and response registers
   always_ff @(posedge sys_clk_i or negedge sys_resetn_i) begin
      if (!sys_resetn_i) begin
         lfsr_q         <= LFSR_SEED;
         ro_stall_cnt_q <= '0;
         wo_stall_cnt_q <= '0;
         ro_rvalid_q    <= 1'b0;
         wo_rvalid_q    <= 1'b0;
         ro_rdata_q     <= '0;
         wo_rdata_q     <= '0;
         ro_cnt_q       <= 16'd0;
         wo_cnt_q       <= 16'd0;
         addr_err_q     <= 1'b0;
      end else begin
         lfsr_q         <= lfsr_d;
         ro_stall_cnt_q <= ro_stall_cnt_d;
         wo_stall_cnt_q <= wo_stall_cnt_d;
         ro_rvalid_q    <= ro_rvalid_d;
         wo_rvalid_q    <= wo_rvalid_d;
         ro_rdata_q     <= ro_rdata_d;
         wo_rdata_q     <= wo_rdata_d;
         ro_cnt_q       <= ro_cnt_d;
         wo_cnt_q       <= wo_cnt_d;
         addr_err_q     <= addr_err_d;
      end
   end

   // Memory array; wo lanes are written last so they win a same-index collision
   always_ff @(posedge sys_clk_i) begin
      for (int b = 0; b < BE_W; b++) begin
         if (ro_we && L2_ro_be_i[b]) begin
            mem_q[ro_idx][8*b +: 8] <= L2_ro_wdata_i[8*b +: 8];
         end
         if (wo_we && L2_wo_be_i[b]) begin
            mem_q[wo_idx][8*b +: 8] <= L2_wo_wdata_i[8*b +: 8];
         end
      end
   end

   assign L2_ro_gnt_o    = ro_gnt;
   assign L2_wo_gnt_o    = wo_gnt;
   assign L2_ro_rvalid_o = ro_rvalid_q;
   assign L2_wo_rvalid_o = wo_rvalid_q;
   assign L2_ro_rdata_o  = ro_rdata_q;
   assign L2_wo_rdata_o  = wo_rdata_q;
   assign ro_cnt_o       = ro_cnt_q;
   assign wo_cnt_o       = wo_cnt_q;
   assign addr_err_o     = addr_err_q;

endmodule
